// File: rtl/fdiv_d_arbiter.sv
// Two-requester round-robin front end for a shared double-precision divider.
// Define FDIV_D_ARB_WATCHDOG_EN to compile in the WAIT-state timeout watchdog.
module fdiv_d_arbiter #(
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_req0_valid,
    input  logic [63:0] i_req0_a,
    input  logic [63:0] i_req0_b,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [63:0] i_req1_a,
    input  logic [63:0] i_req1_b,
    output logic        o_req1_ready,
    output logic        o_div_ena,
    output logic [63:0] o_div_a,
    output logic [63:0] o_div_b,
    input  logic        i_div_valid,
    input  logic [63:0] i_div_res,
    input  logic [2:0]  i_div_flags,
    output logic        o_resp_valid,
    output logic        o_resp_id,
    output logic [63:0] o_resp_res,
    output logic [2:0]  o_resp_flags,
    output logic        o_resp_timeout,
    input  logic        i_resp_ready,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } stateT;

    localparam logic [63:0] TIMEOUT_RES   = 64'h7FF8_0000_0000_0000;
    localparam logic [2:0]  TIMEOUT_FLAGS = 3'b100;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : gBadTimeout
        $error("fdiv_d_arbiter: TIMEOUT_CYCLES must lie in 1..127");
    end

    stateT       state;
    stateT       nextState;
    logic        grantValid;
    logic        grantId;
    logic        lastGrant;
    logic        timeoutHit;
    logic [63:0] opA;
    logic [63:0] opB;
    logic        respId;
    logic [63:0] respRes;
    logic [2:0]  respFlags;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (i_req0_valid || i_req1_valid) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT:    if (i_div_valid || timeoutHit)     nextState = RESP;
            RESP:    if (i_resp_ready)                  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        grantValid   = 1'b0;
        grantId      = 1'b0;
        o_div_ena    = 1'b0;
        o_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (i_req0_valid && i_req1_valid) begin
                    grantValid = 1'b1;
                    grantId    = ~lastGrant;
                end else if (i_req0_valid) begin
                    grantValid = 1'b1;
                    grantId    = 1'b0;
                end else if (i_req1_valid) begin
                    grantValid = 1'b1;
                    grantId    = 1'b1;
                end
            end
            ISSUE:   o_div_ena    = 1'b1;
            RESP:    o_resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_req0_ready = grantValid & ~grantId;
    assign o_req1_ready = grantValid &  grantId;
    assign o_busy       = (state != IDLE);
    assign o_div_a      = opA;
    assign o_div_b      = opB;
    assign o_resp_id    = respId;
    assign o_resp_res   = respRes;
    assign o_resp_flags = respFlags;

    // NOTE: latched data clears on reset so nothing stale from an abandoned transaction reaches the outputs.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            lastGrant <= 1'b1;
            opA       <= '0;
            opB       <= '0;
            respId    <= 1'b0;
            respRes   <= '0;
            respFlags <= '0;
        end else begin
            if (grantValid) begin
                lastGrant <= grantId;
                respId    <= grantId;
                opA       <= grantId ? i_req1_a : i_req0_a;
                opB       <= grantId ? i_req1_b : i_req0_b;
            end
            if (state == WAIT) begin
                if (i_div_valid) begin
                    respRes   <= i_div_res;
                    respFlags <= i_div_flags;
                end else if (timeoutHit) begin
                    respRes   <= TIMEOUT_RES;
                    respFlags <= TIMEOUT_FLAGS;
                end
            end
        end
    end

`ifdef FDIV_D_ARB_WATCHDOG_EN
    localparam logic [6:0] WD_LAST = 7'(TIMEOUT_CYCLES - 1);

    logic [6:0] wdCount;
    logic       respTimeout;

    // Counter holds the number of WAIT cycles already spent; a real result on the last one wins.
    always_ff @(posedge i_clk) begin
        if (!i_nrst)               wdCount <= '0;
        else if (state == ISSUE)   wdCount <= '0;
        else if (state == WAIT)    wdCount <= wdCount + 7'd1;
    end

    assign timeoutHit = (state == WAIT) && !i_div_valid && (wdCount == WD_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            respTimeout <= 1'b0;
        end else if (state == WAIT) begin
            if (i_div_valid)     respTimeout <= 1'b0;
            else if (timeoutHit) respTimeout <= 1'b1;
        end
    end

    assign o_resp_timeout = respTimeout;
`else
    assign timeoutHit     = 1'b0;
    assign o_resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_d_arbiter.sv
// Self-checking bench for fdiv_d_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the round-robin arbiter and a stub divider.
module tb_fdiv_d_arbiter;

    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_req0_valid, i_req1_valid;
    logic [63:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic        o_req0_ready, o_req1_ready;
    logic        o_div_ena;
    logic [63:0] o_div_a, o_div_b;
    logic        i_div_valid;
    logic [63:0] i_div_res;
    logic [2:0]  i_div_flags;
    logic        o_resp_valid, o_resp_id, o_resp_timeout;
    logic [63:0] o_resp_res;
    logic [2:0]  o_resp_flags;
    logic        i_resp_ready;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    fdiv_d_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_req0_valid(i_req0_valid), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .o_req1_ready(o_req1_ready),
        .o_div_ena(o_div_ena), .o_div_a(o_div_a), .o_div_b(o_div_b),
        .i_div_valid(i_div_valid), .i_div_res(i_div_res), .i_div_flags(i_div_flags),
        .o_resp_valid(o_resp_valid), .o_resp_id(o_resp_id), .o_resp_res(o_resp_res),
        .o_resp_flags(o_resp_flags), .o_resp_timeout(o_resp_timeout), .i_resp_ready(i_resp_ready),
        .o_busy(o_busy)
    );

    int nTests = 0;
    int nFail  = 0;

    // Stub divider: answers L cycles after the cycle in which it sees o_div_ena.
    bit          stubOn, stubPending, stubFired, stubFixed;
    int          stubCount, stubLat;
    logic [63:0] stubRes, stubFixedRes;
    logic [2:0]  stubFlags, stubFixedFlags;

    task automatic step();
        if (stubOn && o_div_ena === 1'b1) begin
            stubPending = 1'b1;
            stubCount   = (stubLat > 0) ? stubLat : int'($urandom_range(1, 6));
        end
        @(posedge i_clk);
        #1;
        stubFired   = 1'b0;
        i_div_valid = 1'b0;
        i_div_res   = {$urandom, $urandom};
        i_div_flags = 3'($urandom);
        if (stubPending) begin
            stubCount--;
            if (stubCount == 0) begin
                stubPending = 1'b0;
                stubFired   = 1'b1;
                stubRes     = stubFixed ? stubFixedRes   : {$urandom, $urandom};
                stubFlags   = stubFixed ? stubFixedFlags : 3'($urandom);
                i_div_valid = 1'b1;
                i_div_res   = stubRes;
                i_div_flags = stubFlags;
            end
        end
    endtask

    task automatic applyReset();
        i_nrst = 1'b0;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_req0_a = '0; i_req0_b = '0; i_req1_a = '0; i_req1_b = '0;
        i_resp_ready = 1'b0;
        stubOn = 1'b0; stubPending = 1'b0; stubFixed = 1'b0; stubLat = 0;
        step();
        step();
        i_nrst = 1'b1;
        #1;
    endtask

    function automatic logic [201:0] snapshot();
        return {o_req0_ready, o_req1_ready, o_div_ena, o_div_a, o_div_b, o_resp_valid,
                o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout, o_busy};
    endfunction

    task automatic test_reset();
        applyReset();
        nTests++;
        if (snapshot() !== '0) begin nFail++; $display("FAIL reset_outputs got %h exp 0", snapshot()); end
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            nTests++;
            if (snapshot() !== '0) begin nFail++; $display("FAIL reset_idle_%0d got %h exp 0", k, snapshot()); end
        end
    endtask

    task automatic test_single();
        logic [63:0] a = 64'h4000_0000_0000_0000;
        logic [63:0] b = 64'h3FF0_0000_0000_0000;
        applyReset();
        stubOn = 1'b1; stubFixed = 1'b1; stubLat = 5;
        stubFixedRes = 64'h4000_0000_0000_0000; stubFixedFlags = 3'b000;
        step();
        i_req0_valid = 1'b1; i_req0_a = a; i_req0_b = b;
        #1;
        nTests++;
        if ({o_req0_ready, o_req1_ready} !== 2'b10) begin
            nFail++; $display("FAIL single_ready got %b exp 10", {o_req0_ready, o_req1_ready});
        end
        for (int k = 1; k <= 7; k++) begin
            step();
            i_req0_valid = 1'b0;
            #1;
            nTests++;
            if (o_div_ena !== (k == 1)) begin nFail++; $display("FAIL single_ena T+%0d got %b", k, o_div_ena); end
            nTests++;
            if (o_resp_valid !== (k == 7)) begin nFail++; $display("FAIL single_rv T+%0d got %b", k, o_resp_valid); end
            if (k == 1) begin
                nTests++;
                if ({o_div_a, o_div_b} !== {a, b}) begin
                    nFail++; $display("FAIL single_ops got %h %h exp %h %h", o_div_a, o_div_b, a, b);
                end
            end
        end
        nTests++;
        if ({o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout} !== {1'b0, 64'h4000_0000_0000_0000, 3'b000, 1'b0}) begin
            nFail++; $display("FAIL single_resp got id %b res %h fl %b to %b", o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout);
        end
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;
        #1;
        nTests++;
        if ({o_resp_valid, o_busy} !== 2'b00) begin nFail++; $display("FAIL single_retire got %b exp 00", {o_resp_valid, o_busy}); end
    endtask

    // Transaction-level model: one transaction in flight, tie goes to whoever was not served last.
    task automatic traffic(input string tag, input bit holdBoth, input int nTxn);
        bit          outstanding, expEna, expResp, lastSrv, w, granted, v0, v1, expId;
        logic [63:0] curA[2], curB[2];
        logic [63:0] expA, expB, expRes;
        logic [2:0]  expFlags;
        int          done, budget, grantIdx;
        applyReset();
        stubOn = 1'b1; stubFixed = 1'b0; stubLat = 0;
        outstanding = 0; expEna = 0; expResp = 0; lastSrv = 1; expId = 0;
        expA = '0; expB = '0; expRes = '0; expFlags = '0;
        done = 0; budget = 0; grantIdx = 0;
        for (int r = 0; r < 2; r++) begin curA[r] = {$urandom, $urandom}; curB[r] = {$urandom, $urandom}; end
        while (done < nTxn && budget < 3000) begin
            step();
            budget++;
            v0 = holdBoth ? 1'b1 : 1'($urandom);
            v1 = holdBoth ? 1'b1 : 1'($urandom);
            i_req0_valid = v0; i_req0_a = curA[0]; i_req0_b = curB[0];
            i_req1_valid = v1; i_req1_a = curA[1]; i_req1_b = curB[1];
            i_resp_ready = ($urandom_range(0, 2) == 0);
            #1;
            granted = 1'b0;
            w       = 1'b0;
            if (!outstanding && (v0 || v1)) begin
                granted = 1'b1;
                if (v0 && v1) w = ~lastSrv;
                else          w = v1;
            end
            nTests++;
            if ({o_req0_ready, o_req1_ready} !== {granted & ~w, granted & w}) begin
                nFail++; $display("FAIL %s ready cyc %0d got %b exp %b", tag, budget, {o_req0_ready, o_req1_ready}, {granted & ~w, granted & w});
            end
            if (holdBoth && granted) begin
                nTests++;
                if (o_req1_ready !== 1'(grantIdx % 2)) begin
                    nFail++; $display("FAIL %s alternation grant %0d got ready1 %b", tag, grantIdx, o_req1_ready);
                end
                grantIdx++;
            end
            nTests++;
            if ({o_busy, o_div_ena, o_resp_valid} !== {outstanding, expEna, expResp}) begin
                nFail++; $display("FAIL %s ctrl cyc %0d got %b exp %b", tag, budget, {o_busy, o_div_ena, o_resp_valid}, {outstanding, expEna, expResp});
            end
            if (expEna) begin
                nTests++;
                if ({o_div_a, o_div_b} !== {expA, expB}) begin
                    nFail++; $display("FAIL %s ops got %h %h exp %h %h", tag, o_div_a, o_div_b, expA, expB);
                end
            end
            if (expResp) begin
                nTests++;
                if ({o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout} !== {expId, expRes, expFlags, 1'b0}) begin
                    nFail++; $display("FAIL %s resp got id %b res %h fl %b to %b exp id %b res %h fl %b",
                                      tag, o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout, expId, expRes, expFlags);
                end
            end
            expEna = granted;
            if (expResp && i_resp_ready) begin expResp = 0; outstanding = 0; done++; end
            if (stubFired) begin expResp = 1; expRes = stubRes; expFlags = stubFlags; end
            if (granted) begin
                outstanding = 1; expId = w; expA = curA[w]; expB = curB[w]; lastSrv = w;
                curA[w] = {$urandom, $urandom}; curB[w] = {$urandom, $urandom};
            end
        end
        nTests++;
        if (done < nTxn) begin nFail++; $display("FAIL %s budget: %0d of %0d transactions completed", tag, done, nTxn); end
        i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] eRes;
        logic [2:0]  eFlags;
        applyReset();
        stubOn = 1'b1; stubFixed = 1'b0; stubLat = 3;
        eRes = '0; eFlags = '0;
        step();
        i_req1_valid = 1'b1; i_req1_a = {$urandom, $urandom}; i_req1_b = {$urandom, $urandom};
        #1;
        nTests++;
        if ({o_req0_ready, o_req1_ready} !== 2'b01) begin nFail++; $display("FAIL bp_lone_grant got %b exp 01", {o_req0_ready, o_req1_ready}); end
        for (int k = 1; k <= 5; k++) begin
            step();
            i_req1_valid = 1'b0;
            if (stubFired) begin eRes = stubRes; eFlags = stubFlags; end
            #1;
            nTests++;
            if (o_resp_valid !== (k == 5)) begin nFail++; $display("FAIL bp_latency T+%0d got %b", k, o_resp_valid); end
        end
        stubOn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            i_req0_valid = 1'b1; i_req1_valid = 1'($urandom); i_resp_ready = 1'b0;
            if (k % 3 == 0) begin i_div_valid = 1'b1; i_div_res = {$urandom, $urandom}; i_div_flags = 3'($urandom); end
            #1;
            nTests++;
            if ({o_resp_valid, o_resp_id, o_resp_res, o_resp_flags, o_req0_ready, o_req1_ready, o_div_ena, o_busy}
                !== {1'b1, 1'b1, eRes, eFlags, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                nFail++; $display("FAIL bp_hold %0d got rv %b id %b res %h fl %b rdy %b%b exp res %h fl %b",
                                  k, o_resp_valid, o_resp_id, o_resp_res, o_resp_flags, o_req0_ready, o_req1_ready, eRes, eFlags);
            end
        end
        step();
        i_resp_ready = 1'b1; i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #1;
        nTests++;
        if ({o_resp_valid, o_req0_ready, o_req1_ready} !== 3'b100) begin
            nFail++; $display("FAIL bp_complete got %b exp 100", {o_resp_valid, o_req0_ready, o_req1_ready});
        end
        step();
        i_resp_ready = 1'b0;
        #1;
        nTests++;
        if ({o_resp_valid, o_busy, o_req0_ready, o_req1_ready} !== 4'b0010) begin
            nFail++; $display("FAIL bp_next_grant got %b exp 0010", {o_resp_valid, o_busy, o_req0_ready, o_req1_ready});
        end
        step();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        applyReset();
        stubOn = 1'b1; stubFixed = 1'b1; stubLat = 2;
        stubFixedRes = 64'hC0FF_EE00_1234_5678; stubFixedFlags = 3'b011;
        step();
        i_req1_valid = 1'b1; i_req1_a = {$urandom, $urandom}; i_req1_b = {$urandom, $urandom};
        for (int k = 1; k <= 4; k++) begin
            step();
            i_req1_valid = 1'b0;
        end
        #1;
        nTests++;
        if ({o_resp_valid, o_resp_id, o_resp_res} !== {1'b1, 1'b1, 64'hC0FF_EE00_1234_5678}) begin
            nFail++; $display("FAIL rm_first got rv %b id %b res %h", o_resp_valid, o_resp_id, o_resp_res);
        end
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;
        stubOn = 1'b0;
        i_req0_valid = 1'b1; i_req0_a = {$urandom, $urandom}; i_req0_b = {$urandom, $urandom};
        step();
        i_req0_valid = 1'b0;
        step();
        step();
        #1;
        nTests++;
        if ({o_busy, o_resp_valid} !== 2'b10) begin nFail++; $display("FAIL rm_in_wait got %b exp 10", {o_busy, o_resp_valid}); end
        i_nrst = 1'b0;
        step();
        i_nrst = 1'b1;
        #1;
        nTests++;
        if (snapshot() !== '0) begin nFail++; $display("FAIL rm_cleared got %h exp 0", snapshot()); end
        i_div_valid = 1'b1; i_div_res = {$urandom, $urandom}; i_div_flags = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            nTests++;
            if ({o_resp_valid, o_busy, o_resp_res} !== '0) begin
                nFail++; $display("FAIL rm_stale %0d got rv %b busy %b res %h", k, o_resp_valid, o_busy, o_resp_res);
            end
        end
        step();
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #1;
        nTests++;
        if ({o_req0_ready, o_req1_ready} !== 2'b10) begin nFail++; $display("FAIL rm_first_tie got %b exp 10", {o_req0_ready, o_req1_ready}); end
        step();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    endtask

    task automatic test_idle_div_valid();
        applyReset();
        for (int k = 0; k < 6; k++) begin
            step();
            i_div_valid = (k == 0) ? 1'b1 : 1'($urandom);
            i_div_res = {$urandom, $urandom}; i_div_flags = 3'($urandom);
            #1;
            nTests++;
            if (snapshot() !== '0) begin nFail++; $display("FAIL idle_div_valid %0d got %h exp 0", k, snapshot()); end
        end
    endtask

`ifdef FDIV_D_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        logic [63:0] late = {$urandom, $urandom};
        applyReset();
        step();
        i_req0_valid = 1'b1; i_req0_a = {$urandom, $urandom}; i_req0_b = {$urandom, $urandom};
        for (int k = 1; k <= 10; k++) begin
            step();
            i_req0_valid = 1'b0;
            #1;
            nTests++;
            if (o_resp_valid !== (k == 10)) begin nFail++; $display("FAIL wd_rv T+%0d got %b", k, o_resp_valid); end
        end
        nTests++;
        if ({o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout} !== {1'b0, 64'h7FF8_0000_0000_0000, 3'b100, 1'b1}) begin
            nFail++; $display("FAIL wd_resp got id %b res %h fl %b to %b", o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout);
        end
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;
        i_req1_valid = 1'b1; i_req1_a = {$urandom, $urandom}; i_req1_b = {$urandom, $urandom};
        for (int k = 1; k <= 10; k++) begin
            step();
            i_req1_valid = 1'b0;
            if (k == 9) begin i_div_valid = 1'b1; i_div_res = late; i_div_flags = 3'b010; end
            #1;
            nTests++;
            if (o_resp_valid !== (k == 10)) begin nFail++; $display("FAIL wd_edge_rv T+%0d got %b", k, o_resp_valid); end
        end
        nTests++;
        if ({o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout} !== {1'b1, late, 3'b010, 1'b0}) begin
            nFail++; $display("FAIL wd_edge_resp got id %b res %h fl %b to %b exp res %h", o_resp_id, o_resp_res, o_resp_flags, o_resp_timeout, late);
        end
    endtask
`else
    task automatic test_no_watchdog();
        logic [63:0] late = {$urandom, $urandom};
        applyReset();
        step();
        i_req0_valid = 1'b1; i_req0_a = {$urandom, $urandom}; i_req0_b = {$urandom, $urandom};
        for (int k = 1; k <= 40; k++) begin
            step();
            i_req0_valid = 1'b0;
            #1;
            nTests++;
            if ({o_busy, o_resp_valid, o_resp_timeout} !== 3'b100) begin
                nFail++; $display("FAIL nowd_wait T+%0d got %b exp 100", k, {o_busy, o_resp_valid, o_resp_timeout});
            end
        end
        step();
        i_div_valid = 1'b1; i_div_res = late; i_div_flags = 3'b001;
        step();
        #1;
        nTests++;
        if ({o_resp_valid, o_resp_res, o_resp_flags, o_resp_timeout} !== {1'b1, late, 3'b001, 1'b0}) begin
            nFail++; $display("FAIL nowd_resp got rv %b res %h fl %b to %b exp res %h", o_resp_valid, o_resp_res, o_resp_flags, o_resp_timeout, late);
        end
    endtask
`endif

    initial begin
        i_nrst = 1'b0; i_div_valid = 1'b0; i_div_res = '0; i_div_flags = '0;
        test_reset();
        test_single();
        traffic("round_robin", 1'b1, 8);
        traffic("random", 1'b0, 30);
        test_backpressure();
        test_reset_mid();
        test_idle_div_valid();
`ifdef FDIV_D_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
